// File: rtl/countdown_timer_pkg.sv
// Shared constants and helpers for the countdown timer: state encodings,
// seconds limit and prescaler width.
package countdown_timer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_PAUSE = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam logic [5:0] SEC_MAX = 6'd59;

   // Wide enough for the largest legal TICKS_PER_SEC (1023).
   localparam int unsigned PRESC_W = 10;

   function automatic logic [5:0] clamp_sec(input logic [5:0] s);
      return (s > SEC_MAX) ? SEC_MAX : s;
   endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Emits a one-cycle pulse per rise of d, two edges after the rise is first sampled.
module sync_rise_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise
);

   logic       sync1_q;
   logic       sync2_q;
   logic       prev_q;
   logic       armed_q;
   logic       rise_q;
   logic [1:0] fill_q;

   // armed_q only sets once the synchronizer holds real data that is low, so a
   // level already high at reset release never looks like a rise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         rise_q  <= 1'b0;
         fill_q  <= 2'b00;
      end else begin
         sync1_q <= d;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         fill_q  <= {fill_q[0], 1'b1};
         armed_q <= armed_q | (fill_q[1] & ~sync2_q);
         rise_q  <= armed_q & sync2_q & ~prev_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer driven by an asynchronous divided tick clock,
// with load/start/pause commands and a one-cycle done pulse at 00:00.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 10,
   parameter int unsigned MAX_MIN       = 99
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick_clk,
   input  logic       start,
   input  logic       pause,
   input  logic       load,
   input  logic [6:0] load_min,
   input  logic [5:0] load_sec,
   output logic [6:0] min_out,
   output logic [5:0] sec_out,
   output logic       running,
   output logic       done,
   output logic [1:0] state_out
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = 1;
   localparam logic [6:0]         MIN_LIMIT  = 7'(MAX_MIN);

   logic               tick_pulse;
   logic               sec_strobe;
   state_t             state_q, state_d;
   logic [6:0]         min_q, min_d;
   logic [5:0]         sec_q, sec_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               done_q, done_d;
   logic               running_q, running_d;

   sync_rise_detect u_tick_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (tick_clk),
      .rise    (tick_pulse)
   );

   assign sec_strobe = (state_q == ST_RUN) && tick_pulse && (presc_q == PRESC_LAST);

   // load > pause > start; start is only honoured when pause is low.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      presc_d = presc_q;
      done_d  = 1'b0;

      if (load) begin
         state_d = ST_IDLE;
         min_d   = (load_min > MIN_LIMIT) ? MIN_LIMIT : load_min;
         sec_d   = clamp_sec(load_sec);
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !pause && ((min_q != 7'd0) || (sec_q != 6'd0))) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSE;
               end else if (sec_strobe) begin
                  presc_d = '0;
                  if (sec_q != 6'd0) begin
                     sec_d = sec_q - 6'd1;
                  end else if (min_q != 7'd0) begin
                     min_d = min_q - 7'd1;
                     sec_d = SEC_MAX;
                  end
                  if ((min_q == 7'd0) && (sec_q <= 6'd1)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else if (tick_pulse) begin
                  presc_d = presc_q + PRESC_ONE;
               end
            end
            ST_PAUSE: begin
               if (start && !pause) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         min_q     <= 7'd0;
         sec_q     <= 6'd0;
         presc_q   <= '0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         presc_q   <= presc_d;
         done_q    <= done_d;
         running_q <= running_d;
      end
   end

   assign min_out   = min_q;
   assign sec_out   = sec_q;
   assign running   = running_q;
   assign done      = done_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=2 (two tick rises per second).
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick_clk = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       load = 1'b0;
   logic [6:0] load_min = 7'd0;
   logic [5:0] load_sec = 6'd0;
   logic [6:0] min_out;
   logic [5:0] sec_out;
   logic       running;
   logic       done;
   logic [1:0] state_out;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done_ref = 0;

   localparam int IDLE = 0, RUN = 1, PAUSED = 2, DONE = 3;

   always #5 clk = ~clk;

   countdown_timer #(
      .TICKS_PER_SEC (2),
      .MAX_MIN       (99)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_clk  (tick_clk),
      .start     (start),
      .pause     (pause),
      .load      (load),
      .load_min  (load_min),
      .load_sec  (load_sec),
      .min_out   (min_out),
      .sec_out   (sec_out),
      .running   (running),
      .done      (done),
      .state_out (state_out)
   );

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int st, input int mn, input int sc);
      chk({tag, " state"}, int'(state_out), st);
      chk({tag, " min"}, int'(min_out), mn);
      chk({tag, " sec"}, int'(sec_out), sc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [6:0] m, input logic [5:0] s);
      load_min = m;
      load_sec = s;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1;
      step();
      pause = 1'b0;
   endtask

   task automatic rise(input int n);
      for (int i = 0; i < n; i++) begin
         tick_clk = 1'b1;
         repeat (5) step();
         tick_clk = 1'b0;
         repeat (5) step();
      end
   endtask

   initial begin
      step();
      step();
      chk_out("reset", IDLE, 0, 0);
      chk("reset running", int'(running), 0);
      chk("reset done", int'(done), 0);
      reset_n = 1'b1;
      repeat (5) step();

      // 0:03 countdown to DONE
      do_load(7'd0, 6'd3);
      chk_out("t1 load", IDLE, 0, 3);
      do_start();
      chk("t1 start state", int'(state_out), RUN);
      chk("t1 running", int'(running), 1);
      rise(1);
      chk("t1 rise1 sec", int'(sec_out), 3);
      rise(1);
      chk("t1 rise2 sec", int'(sec_out), 2);
      rise(2);
      chk("t1 rise4 sec", int'(sec_out), 1);
      rise(2);
      chk_out("t1 end", DONE, 0, 0);
      chk("t1 done pulses", done_cnt, 1);
      chk("t1 running end", int'(running), 0);
      do_start();
      do_pause();
      chk_out("t1 done hold", DONE, 0, 0);

      // minute borrow
      do_load(7'd1, 6'd0);
      do_start();
      rise(2);
      chk_out("t2 borrow", RUN, 0, 59);

      // pause and resume keeps prescaler
      do_load(7'd0, 6'd5);
      do_start();
      rise(1);
      do_pause();
      chk("t3 paused state", int'(state_out), PAUSED);
      rise(4);
      chk_out("t3 paused", PAUSED, 0, 5);
      do_start();
      chk("t3 resume state", int'(state_out), RUN);
      rise(1);
      chk("t3 resume sec", int'(sec_out), 4);

      // clamp and priority
      load_min = 7'd120;
      load_sec = 6'd63;
      load = 1'b1;
      pause = 1'b1;
      start = 1'b1;
      step();
      load = 1'b0;
      pause = 1'b0;
      start = 1'b0;
      chk_out("t4 clamp", IDLE, 99, 59);
      chk("t4 running", int'(running), 0);

      // load coinciding with the final sec_strobe
      done_ref = done_cnt;
      do_load(7'd0, 6'd1);
      do_start();
      rise(1);
      chk_out("t5 pre", RUN, 0, 1);
      tick_clk = 1'b1;
      repeat (3) step();
      load_min = 7'd0;
      load_sec = 6'd7;
      load = 1'b1;
      step();
      load = 1'b0;
      chk_out("t5 load wins", IDLE, 0, 7);
      tick_clk = 1'b0;
      repeat (5) step();
      chk("t5 no done", done_cnt, done_ref);
      do_load(7'd0, 6'd0);
      do_start();
      chk("t5 zero start", int'(state_out), IDLE);
      chk("t5 zero running", int'(running), 0);

      // reset mid-run with tick_clk held high
      do_load(7'd0, 6'd10);
      do_start();
      tick_clk = 1'b1;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("t6 reset", IDLE, 0, 0);
      chk("t6 reset running", int'(running), 0);
      chk("t6 reset done", int'(done), 0);
      step();
      step();
      chk("t6 no done", done_cnt, done_ref);
      reset_n = 1'b1;
      do_load(7'd0, 6'd3);
      do_start();
      repeat (10) step();
      chk_out("t6 held high", RUN, 0, 3);
      tick_clk = 1'b0;
      repeat (5) step();
      rise(1);
      chk("t6 fresh rise1", int'(sec_out), 3);
      rise(1);
      chk("t6 fresh rise2", int'(sec_out), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
